// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the arbitrated 32x32 multiplier.
// S1 and S2 entry structs carry an id field sized for the largest
// supported requester count (8), so one struct fits all NUM_REQ values.
package mult_arbiter_pkg;

    localparam int MUL_W    = 32;
    localparam int PROD_W   = 64;
    localparam int ID_MAX_W = 3;

    // Operand stage: absolute operands plus the sign of the final product
    typedef struct packed {
        logic                valid;
        logic                neg;
        logic [ID_MAX_W-1:0] id;
        logic [MUL_W-1:0]    a;
        logic [MUL_W-1:0]    b;
    } s1_entry_t;

    // Result stage: finished product and the requester that owns it
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic [PROD_W-1:0]   prod;
    } s2_entry_t;

    // Magnitude of a two's-complement operand; the most negative value
    // maps onto itself, which is still correct as an unsigned magnitude
    function automatic logic [MUL_W-1:0] abs_val(input logic [MUL_W-1:0] x);
        return x[MUL_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mult_arbiter_wallace.sv
// Unsigned 32x32 -> 64 multiplier core shared by all requesters.
// Purely combinational; the surrounding pipeline registers its inputs
// (S1) and its output (S2).
module wallace_32x32
    import mult_arbiter_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] prod
);

    assign prod = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding one shared 32x32 multiplier through a
// two-stage pipeline (S1 operands, S2 product) with a valid/ready
// response port. Results leave in acceptance order.
// Optional build macro: MULT_ARBITER_SIGNED_EN enables signed products
// (S1 stores magnitudes and a negate flag, S2 applies the sign).
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MUL_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_signed,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [PROD_W-1:0]        rsp_prod,
    output logic                     busy
);

    logic [MUL_W-1:0]  a_arr [NUM_REQ];
    logic [MUL_W-1:0]  b_arr [NUM_REQ];

    s1_entry_t         s1_reg, s1_next;
    s2_entry_t         s2_reg, s2_next;
    logic [ID_W-1:0]   last_grant_reg, last_grant_next;

    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand_idx;
    logic              grant_found;
    logic              s2_adv, s1_adv, can_accept, transfer;

    logic [MUL_W-1:0]  sel_a, sel_b, op_a, op_b;
    logic              op_neg;
    logic [PROD_W-1:0] mul_prod, prod_fixed;
    logic              unused_id;

    // Unpack the per-requester operand slices
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*MUL_W +: MUL_W];
            assign b_arr[gi] = req_b[gi*MUL_W +: MUL_W];
        end
    endgenerate

    // Pipeline flow control: everything moves when the result stage drains
    assign s2_adv     = !s2_reg.valid || rsp_ready;
    assign s1_adv     = s2_adv;
    assign can_accept = !s1_reg.valid || s1_adv;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Ready depends only on valids, rsp_ready and registered state
    assign req_ready = (rst_n && can_accept && grant_found)
                     ? (NUM_REQ'(1) << grant_idx) : '0;
    assign transfer  = |req_ready;

    assign sel_a = a_arr[grant_idx];
    assign sel_b = b_arr[grant_idx];

`ifdef MULT_ARBITER_SIGNED_EN
    logic sel_signed;
    assign sel_signed = req_signed[grant_idx];

    // Signed requests enter S1 as magnitudes plus the product sign
    always_comb begin
        op_a   = sel_signed ? abs_val(sel_a) : sel_a;
        op_b   = sel_signed ? abs_val(sel_b) : sel_b;
        op_neg = sel_signed && (sel_a[MUL_W-1] ^ sel_b[MUL_W-1]);
    end

    // Restore the sign on the way into S2
    always_comb begin
        prod_fixed = s1_reg.neg ? (~mul_prod + 1'b1) : mul_prod;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{req_signed, s1_reg.neg};

    // Unsigned-only build: operands pass straight through
    always_comb begin
        op_a   = sel_a;
        op_b   = sel_b;
        op_neg = 1'b0;
    end

    // Unsigned-only build: product needs no correction
    always_comb begin
        prod_fixed = mul_prod;
    end
`endif

    // S1 loads whenever it may accept; it becomes empty if nobody transfers
    always_comb begin
        s1_next = s1_reg;
        if (can_accept) begin
            s1_next.valid = transfer;
            s1_next.neg   = op_neg;
            s1_next.id    = ID_MAX_W'(grant_idx);
            s1_next.a     = op_a;
            s1_next.b     = op_b;
        end
    end

    wallace_32x32 u_mul (
        .a    (s1_reg.a),
        .b    (s1_reg.b),
        .prod (mul_prod)
    );

    // S2 captures the multiplier output whenever the consumer lets it move
    always_comb begin
        s2_next = s2_reg;
        if (s2_adv) begin
            s2_next.valid = s1_reg.valid;
            s2_next.id    = s1_reg.id;
            s2_next.prod  = prod_fixed;
        end
    end

    // Round-robin pointer moves only on an actual transfer
    always_comb begin
        last_grant_next = transfer ? grant_idx : last_grant_reg;
    end

    // State registers; reset empties the pipeline and favours requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg         <= '0;
            s2_reg         <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            s1_reg         <= s1_next;
            s2_reg         <= s2_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign rsp_valid = s2_reg.valid;
    assign rsp_id    = s2_reg.id[ID_W-1:0];
    assign rsp_prod  = s2_reg.prod;
    assign busy      = s1_reg.valid || s2_reg.valid;
    assign unused_id = ^s2_reg.id;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and short random checks of mult_arbiter (NUM_REQ=4) against a
// small bench-side model of the round-robin order and the products.
module tb_mult_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] prod;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]  req_signed = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_prod;
    logic          busy;

    int            n_vec = 0;
    int            n_miss = 0;
    int            tb_last = N - 1;
    exp_t          exp_q[$];
    logic          hold_pending = 1'b0;
    logic [1:0]    hold_id;
    logic [63:0]   hold_prod;

    always #5 clk = ~clk;

    mult_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_prod   (rsp_prod),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0]        ua, ub;
        logic signed [63:0] sa, sb;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
`ifdef MULT_ARBITER_SIGNED_EN
        if (s) return 64'(sa * sb);
`else
        if (s && 1'b0) return 64'(sa * sb);
`endif
        return ua * ub;
    endfunction

    function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_signed[i]     = s;
    endtask

    // One clock cycle: check grant and response against the model, then advance
    task automatic cycle();
        logic [N-1:0] er;
        exp_t         e;
        #1;
        er = (exp_q.size() < 2 || rsp_ready) ? rr(req_valid, tb_last) : '0;
        check("req_ready", 64'(req_ready), 64'(er));
        if (rsp_valid && exp_q.size() == 0)
            check("rsp_spurious", 64'(rsp_valid), 64'd0);
        if (hold_pending) begin
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_id", 64'(rsp_id), 64'(hold_id));
            check("hold_prod", rsp_prod, hold_prod);
        end
        if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_prod", rsp_prod, e.prod);
            $display("rsp id=%0d prod=%h", rsp_id, rsp_prod);
        end
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                e.id   = 2'(i);
                e.prod = model(req_a[i*32 +: 32], req_b[i*32 +: 32], req_signed[i]);
                exp_q.push_back(e);
                tb_last = i;
            end
        end
        hold_pending = rsp_valid && !rsp_ready;
        hold_id      = rsp_id;
        hold_prod    = rsp_prod;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_prod", rsp_prod, 64'd0);
        exp_q.delete();
        tb_last      = N - 1;
        hold_pending = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) cycle();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every requester asking: nothing may be granted
        req_valid = '1;
        #1;
        do_reset();
        req_valid = '0;
        @(posedge clk);
        #1;

        // Single requester 2, all-ones unsigned operands
        set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        check("lat_s1_rsp_valid", 64'(rsp_valid), 64'd0);
        check("lat_s1_busy", 64'(busy), 64'd1);
        cycle();
        check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        check("lat_rsp_id", 64'(rsp_id), 64'd2);
        check("lat_rsp_prod", rsp_prod, 64'hFFFF_FFFE_0000_0001);
        cycle();
        check("lat_idle_busy", 64'(busy), 64'd0);

        // All requesters valid, consumer always ready: 0,1,2,3,0,...
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 32'(k * 16 + i + 1), 32'(i + 3), 1'b0);
            req_valid = '1;
            rsp_ready = 1'b1;
            #1;
            check("rr_grant", 64'(req_ready), 64'(N'(1) << (k % N)));
            cycle();
        end
        drain();

        // Back-pressure: two entries fill S1 and S2, everything holds
        rsp_ready = 1'b0;
        set_req(1, 32'd5, 32'd6, 1'b0);
        req_valid = 4'b0010;
        cycle();
        set_req(3, 32'd7, 32'd8, 1'b0);
        req_valid = 4'b1000;
        cycle();
        set_req(0, 32'd9, 32'd9, 1'b0);
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_id", 64'(rsp_id), 64'd1);
            check("stall_rsp_prod", rsp_prod, 64'd30);
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        check("stall_second_id", 64'(rsp_id), 64'd3);
        check("stall_second_prod", rsp_prod, 64'd56);
        cycle();
        check("stall_done_valid", 64'(rsp_valid), 64'd0);

        // -3 * 7 with the signed flag set
        set_req(0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
`ifdef MULT_ARBITER_SIGNED_EN
        check("signed_prod", rsp_prod, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        check("signed_prod", rsp_prod, 64'h0000_0006_FFFF_FFEB);
`endif
        cycle();
        req_signed = '0;

        // Reset while both stages hold entries
        rsp_ready = 1'b0;
        set_req(1, 32'd11, 32'd13, 1'b0);
        req_valid = 4'b0010;
        cycle();
        set_req(2, 32'd17, 32'd19, 1'b0);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        req_valid = '1;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        cycle();
        drain();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            req_valid = N'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 32x32 multiplier (range 2..8).
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), width of requester index.
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-007 req_a  input  NUM_REQ*32  packed multiplicand, slice i for requester i.
REQ-008 req_b  input  NUM_REQ*32  packed multiplier, slice i for requester i.
REQ-009 req_signed  input  NUM_REQ  per-request two's-complement flag.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  ID_W  index of requester owning result.
REQ-013 rsp_prod  output  64  product.
REQ-014 busy  output  1  high while either pipeline stage holds a valid entry.

Function
REQ-015 Transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready SHALL be zero when the pipeline cannot advance; otherwise it is one-hot on the round-robin winner among asserted req_valid, or zero if none.
REQ-017 Round-robin: the search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on a transfer; wrap from NUM_REQ-1 goes to 0.
REQ-018 req_ready SHALL depend combinationally on req_valid, rsp_ready and registered state only, never on req_a/req_b.
REQ-019 Stage S1 (registered operands, id, negate flag, valid) SHALL load on transfer.
REQ-020 Stage S2 (registered 64-bit product, id, valid) SHALL load from the shared multiplier driven by S1.
REQ-021 S2 advances when !s2_valid or rsp_ready.
REQ-022 S1 advances when S2 advances.
REQ-023 A transfer is allowed when !s1_valid or S1 advances.
REQ-024 Latency: a transfer at edge t SHALL present rsp_valid after edge t+1; sustained throughput is one result per cycle when rsp_ready stays high.
REQ-025 rsp_valid/rsp_id/rsp_prod SHALL hold stable while rsp_valid and !rsp_ready.
REQ-026 Results SHALL be returned in acceptance order; no reordering, no drops, no duplicates.
REQ-027 Simultaneous rsp handshake and new transfer in one cycle SHALL both complete, with no bubble.
REQ-028 Unsigned product SHALL equal the exact 64-bit product of zero-extended operands.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear s1_valid and s2_valid and set last_grant to NUM_REQ-1, so requester 0 wins first.
REQ-030 During reset, req_ready, rsp_valid and busy SHALL be 0; rsp_id = 0 and rsp_prod = 0.
REQ-031 Reset mid-operation SHALL discard in-flight entries, with no response emitted after reset release.

Configuration
REQ-032 Macro MULT_ARBITER_SIGNED_EN: when defined, a request with req_signed=1 SHALL yield the 64-bit two's-complement product. S1 stores absolute values and a negate flag (sign_a XOR sign_b); S2 conditionally negates.
REQ-033 When MULT_ARBITER_SIGNED_EN is undefined, req_signed SHALL be ignored and all products are unsigned; ports are unchanged.

Structure
REQ-034 Shared package mult_arbiter_pkg SHALL hold MUL_W=32, PROD_W=64 and the S1/S2 entry struct typedefs.
REQ-035 The sole sub-module SHALL be one instance of the existing wallace_32x32 multiplier between S1 and S2; no second multiplier.

Verification
REQ-036 Requester 2 only, a=0xFFFFFFFF, b=0xFFFFFFFF, unsigned -> rsp_prod=0xFFFFFFFE00000001, rsp_id=2, rsp_valid two cycles after transfer.
REQ-037 All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence identical.
REQ-038 rsp_ready held low for 5 cycles with two requests accepted -> rsp_valid and its data stable, req_ready all zero once S1 and S2 are full; both results delivered in order after release.
REQ-039 With MULT_ARBITER_SIGNED_EN, a=-3 (0xFFFFFFFD), b=7, signed -> rsp_prod=0xFFFFFFFFFFFFFFEB. Without the macro, the same stimulus -> 0x00000006FFFFFFEB.
REQ-040 rst_n pulsed low while S1 and S2 are valid -> rsp_valid=0 at once, busy=0, no stale response later, and the next grant goes to requester 0.
REQ-041 Random 10k requests with random valid/ready against a reference model -> all products correct, ordered, and one-hot req_ready.
